i2c_sel_ctrl: RTL

//  Upstream controller for the multi-port I2C mux. Owns the mux `sel` input.

---
 rtl/i2c_mp_pkg.sv | 15 +
 rtl/i2c_sel_ctrl_if.sv | 29 ++
 rtl/i2c_line_filter.sv | 41 ++++
 rtl/i2c_sel_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/i2c_mp_pkg.sv
// Shared types and width helpers for the I2C mux select controller.
package i2c_mp_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_FREE, SETTLE} sel_state_t;

    function automatic int unsigned selw(input int unsigned ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    // Counter width able to hold max(v,2).
    function automatic int unsigned cntw(input int unsigned v);
        return $clog2(((v < 2) ? 2 : v) + 1);
    endfunction

endpackage

// File: rtl/i2c_sel_ctrl_if.sv
// Port-switch request/response channel between a master and the select controller.
interface i2c_sel_ctrl_if #(
    parameter int unsigned PORTS = 2
) ();
    localparam int unsigned SW = i2c_mp_pkg::selw(PORTS);

    logic          req_valid;
    logic [SW-1:0] req_port;
    logic          req_ready;
    logic          done;
    logic          err;

    modport master (
        output req_valid,
        output req_port,
        input  req_ready,
        input  done,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req_port,
        output req_ready,
        output done,
        output err
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a stability filter; preset forces everything to 1.
module i2c_line_filter
    import i2c_mp_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic preset,
    input  logic line,
    output logic level
);
    localparam int unsigned CW = cntw(FILT_LEN);
    localparam logic [CW-1:0] LAST = CW'((FILT_LEN == 0) ? 0 : FILT_LEN - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || preset) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            meta <= line;
            sync <= meta;
            // cnt tracks how many consecutive samples disagree with level
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt >= LAST) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_sel_ctrl.sv
// Owns the I2C mux select: switches ports only on an idle bus, then holds the master off.
module i2c_sel_ctrl
    import i2c_mp_pkg::*;
#(
    parameter int unsigned PORTS           = 2,
    parameter int unsigned RESET_PORT      = 0,
    parameter int unsigned FILT_LEN        = 4,
    parameter int unsigned BUS_FREE_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES   = 64,
    parameter int unsigned WAIT_TIMEOUT    = 1000000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    i2c_sel_ctrl_if.slave          req,
    output logic [selw(PORTS)-1:0] sel,
    output logic                   hold,
    output logic                   bus_busy,
    input  logic                   sp_scl_i,
    input  logic                   sp_sda_i
);
    localparam int unsigned SW  = selw(PORTS);
    localparam int unsigned FW  = cntw(BUS_FREE_CYCLES);
    localparam int unsigned TW  = cntw(WAIT_TIMEOUT);
    localparam int unsigned STW = cntw(SETTLE_CYCLES);

    localparam logic [FW-1:0]  FREE_LAST   = FW'((BUS_FREE_CYCLES == 0) ? 0 : BUS_FREE_CYCLES - 1);
    localparam logic [TW-1:0]  WAIT_LAST   = TW'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);
    localparam logic [STW-1:0] SETTLE_LAST = STW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

    sel_state_t     state;
    logic [SW-1:0]  target;
    logic [TW-1:0]  wait_cnt;
    logic [STW-1:0] settle_cnt;
    logic [FW-1:0]  free_cnt;
    logic           done;
    logic           err;

    logic scl_f;
    logic sda_f;
    logic sda_prev;
    logic in_settle;
    logic lines_idle;
    logic start;
    logic stop;
    logic free_exp;
    logic switch_now;

    i2c_line_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_scl_filt (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .preset (switch_now),
        .line   (sp_scl_i),
        .level  (scl_f)
    );

    i2c_line_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_sda_filt (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .preset (switch_now),
        .line   (sp_sda_i),
        .level  (sda_f)
    );

    assign in_settle  = (state == SETTLE);
    assign lines_idle = scl_f && sda_f;
    assign start      = !in_settle && scl_f && sda_prev && !sda_f;
    assign stop       = !in_settle && scl_f && !sda_prev && sda_f;
    assign free_exp   = lines_idle && (free_cnt >= FREE_LAST);
    // Also drives the filter preset, so the new port starts from a clean idle view.
    assign switch_now = (state == WAIT_FREE) && !bus_busy && lines_idle;

    assign req.req_ready = (state == IDLE);
    assign req.done      = done;
    assign req.err       = err;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || switch_now) begin
            sda_prev <= 1'b1;
        end else begin
            sda_prev <= sda_f;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || switch_now || in_settle || !lines_idle) begin
            free_cnt <= '0;
        end else if (free_cnt < FREE_LAST) begin
            free_cnt <= free_cnt + FW'(1);
        end
    end

    // START outranks a simultaneous free-timeout.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || switch_now || in_settle) begin
            bus_busy <= 1'b0;
        end else if (start) begin
            bus_busy <= 1'b1;
        end else if (stop || free_exp) begin
            bus_busy <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            sel        <= SW'(RESET_PORT);
            target     <= SW'(RESET_PORT);
            hold       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            wait_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        if (32'(req.req_port) >= PORTS) begin
                            err <= 1'b1;
                        end else if (req.req_port == sel) begin
                            done <= 1'b1;
                        end else begin
                            target   <= req.req_port;
                            state    <= WAIT_FREE;
                            hold     <= 1'b1;
                            wait_cnt <= '0;
                        end
                    end
                end
                WAIT_FREE: begin
                    if (switch_now) begin
                        sel        <= target;
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end else if ((WAIT_TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        hold  <= 1'b0;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt >= SETTLE_LAST) begin
                        done  <= 1'b1;
                        state <= IDLE;
                        hold  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + STW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    hold  <= 1'b0;
                end
            endcase
        end
    end

endmodule
